mem_bank: RTL and testbench

Parametrised memory-mapped register bank for the processor data bus: NUM_REGS word registers at consecutive word addresses from BASE_ADDR, read and written through active-low strobes. Each access is acknowledged by a four-phase handshake. Out-of-range or misaligned accesses are flagged. It replaces fixed three-register decoders on the data-memory port and sits between the core's load/store stage and the peripheral map.

---
 rtl/mem_bank.sv | 130 +++++++++++++
 tb/tb_mem_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank.sv
// ---------------------------------------------------------------------------
// mem_bank
//   Memory-mapped register bank on the processor data bus. NUM_REGS
//   word registers sit at consecutive word addresses starting at BASE_ADDR.
//   Each access uses active-low strobes and completes with a four-phase
//   handshake through Mem_ack. Accesses that are out of range or misaligned
//   are flagged on Mem_err.
//
//   Optional feature macro: MEM_BANK_BYTE_EN. When it is defined, the
//   Mem_be port exists and writes update only the enabled byte lanes.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   Mem_rd        in   read strobe, active-low
//   Mem_wr        in   write strobe, active-low
//   Dir_Mem       in   byte address [ADDR_W]
//   Dato_Mem_in   in   write data [DATA_W]
//   Mem_be        in   byte-lane write enables [DATA_W/8] (MEM_BANK_BYTE_EN only)
//   Dato_Mem_out  out  registered read data [DATA_W]
//   Mem_ack       out  access complete, high while in HOLD
//   Mem_err       out  last access was invalid, qualified by Mem_ack
// ---------------------------------------------------------------------------
module mem_bank #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                NUM_REGS   = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h10000000,
  parameter logic [DATA_W-1:0] DEFAULT_RD = 32'h0000000F
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Mem_rd,
  input  logic                Mem_wr,
  input  logic [ADDR_W-1:0]   Dir_Mem,
  input  logic [DATA_W-1:0]   Dato_Mem_in,
`ifdef MEM_BANK_BYTE_EN
  input  logic [DATA_W/8-1:0] Mem_be,
`endif
  output logic [DATA_W-1:0]   Dato_Mem_out,
  output logic                Mem_ack,
  output logic                Mem_err
);

  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_ack;
  logic              r_err;

  logic [ADDR_W-1:0] w_off;
  logic              w_valid;
  logic [IDX_W-1:0]  w_idx;
  logic              w_req;
  logic              w_is_rd;
  logic [DATA_W-1:0] w_mask;

  // Wrap-around subtraction. Addresses below the base are caught by the
  // explicit comparison, so a wrapped offset is never used.
  assign w_off   = Dir_Mem - BASE_ADDR;
  assign w_valid = (Dir_Mem >= BASE_ADDR) &&
                   (w_off[1:0] == 2'b00) &&
                   ((w_off >> 2) < ADDR_W'(NUM_REGS));
  assign w_idx   = w_off[IDX_W+1:2];

  // A read takes priority when both strobes are low.
  assign w_req   = !Mem_rd || !Mem_wr;
  assign w_is_rd = !Mem_rd;

  // Per-lane write mask. Without byte enables every lane is written.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef MEM_BANK_BYTE_EN
    assign w_mask[gi*8 +: 8] = {8{Mem_be[gi]}};
`else
    assign w_mask[gi*8 +: 8] = 8'hFF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rd_data <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_ack   <= 1'b1;
            r_err   <= !w_valid;
            r_state <= HOLD;
            if (w_is_rd) begin
              r_rd_data <= w_valid ? r_regs[w_idx] : DEFAULT_RD;
            end else if (w_valid) begin
              r_regs[w_idx] <= (r_regs[w_idx] & ~w_mask) | (Dato_Mem_in & w_mask);
            end
          end
        end
        HOLD: begin
          // Outputs stay frozen until both strobes are released, so a
          // strobe held low cannot start a second access.
          if (Mem_rd && Mem_wr) begin
            r_ack   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Dato_Mem_out = r_rd_data;
  assign Mem_ack      = r_ack;
  assign Mem_err      = r_err;

endmodule

// File: tb/tb_mem_bank.sv
// ---------------------------------------------------------------------------
// tb_mem_bank
//   Directed and randomized bench for mem_bank. The reference model keeps a
//   plain array of register words and decodes addresses with integer
//   arithmetic, independent of the design's internals.
// ---------------------------------------------------------------------------
module tb_mem_bank;

  localparam int          NREGS = 8;
  localparam longint      BASE  = 64'h10000000;
  localparam logic [31:0] DEFV  = 32'h0000000F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Mem_rd = 1'b1;
  logic        Mem_wr = 1'b1;
  logic [31:0] Dir_Mem = '0;
  logic [31:0] Dato_Mem_in = '0;
`ifdef MEM_BANK_BYTE_EN
  logic [3:0]  Mem_be = 4'hF;
`endif
  logic [31:0] Dato_Mem_out;
  logic        Mem_ack;
  logic        Mem_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_regs [NREGS];
  logic [31:0] m_out;
  logic        m_err;

  mem_bank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Mem_rd       (Mem_rd),
    .Mem_wr       (Mem_wr),
    .Dir_Mem      (Dir_Mem),
    .Dato_Mem_in  (Dato_Mem_in),
`ifdef MEM_BANK_BYTE_EN
    .Mem_be       (Mem_be),
`endif
    .Dato_Mem_out (Dato_Mem_out),
    .Mem_ack      (Mem_ack),
    .Mem_err      (Mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_out = '0;
    m_err = 1'b0;
  endtask

  // Address decode from first principles: word slot relative to base.
  function automatic bit addr_ok(input logic [31:0] a, output int idx);
    longint off;
    off = longint'(a) - BASE;
    idx = int'(off / 4);
    return (off >= 0) && (off % 4 == 0) && (off / 4 < NREGS);
  endfunction

  task automatic model_access(input bit rd, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be);
    int  idx;
    bit  ok;
    ok = addr_ok(a, idx);
    m_err = !ok;
    if (rd) begin
      m_out = ok ? m_regs[idx] : DEFV;
    end else if (ok) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_regs[idx][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  // One full handshake: request at a negedge, check after the sampling
  // edge, release, check that the acknowledge drops one edge later.
  task automatic access(input string tag, input logic rd_n, input logic wr_n,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    @(negedge clk);
    Mem_rd = rd_n;
    Mem_wr = wr_n;
    Dir_Mem = a;
    Dato_Mem_in = d;
`ifdef MEM_BANK_BYTE_EN
    Mem_be = be;
`endif
    model_access(!rd_n, a, d, be);
    @(posedge clk); #1;
    chk({tag, ".ack"}, {31'd0, Mem_ack}, 32'd1);
    chk({tag, ".err"}, {31'd0, Mem_err}, {31'd0, m_err});
    chk({tag, ".data"}, Dato_Mem_out, m_out);
    @(negedge clk);
    Mem_rd = 1'b1;
    Mem_wr = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".ackdrop"}, {31'd0, Mem_ack}, 32'd0);
    chk({tag, ".dhold"}, Dato_Mem_out, m_out);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < NREGS; i++)
      access(tag, 1'b0, 1'b1, 32'(BASE + 4*i), 32'h0, 4'hF);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int          kind;
    int          op;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ack", {31'd0, Mem_ack}, 32'd0);
    chk("rst.err", {31'd0, Mem_err}, 32'd0);
    chk("rst.data", Dato_Mem_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic read / write / out-of-range
    access("rd_base", 1'b0, 1'b1, 32'h10000000, 32'h0, 4'hF);
    access("wr_1c", 1'b1, 1'b0, 32'h1000001C, 32'hDEADBEEF, 4'hF);
    access("rd_1c", 1'b0, 1'b1, 32'h1000001C, 32'h0, 4'hF);
    access("rd_20", 1'b0, 1'b1, 32'h10000020, 32'h0, 4'hF);
    access("rd_mis", 1'b0, 1'b1, 32'h10000002, 32'h0, 4'hF);
    access("rd_below", 1'b0, 1'b1, 32'h0FFFFFFC, 32'h0, 4'hF);
    access("wr_mis", 1'b1, 1'b0, 32'h10000002, 32'h55555555, 4'hF);
    read_all("post_mis");

    // Both strobes low: read wins, no write
    access("both", 1'b0, 1'b0, 32'h10000004, 32'hA5A5A5A5, 4'hF);
    access("both_chk", 1'b0, 1'b1, 32'h10000004, 32'h0, 4'hF);

    // Strobe held for 5 cycles with the address moving mid-hold
    access("wr_r3", 1'b1, 1'b0, 32'h1000000C, 32'hCAFE0003, 4'hF);
    access("wr_r5", 1'b1, 1'b0, 32'h10000014, 32'h5555AAAA, 4'hF);
    @(negedge clk);
    Mem_rd = 1'b0;
    Dir_Mem = 32'h1000000C;
    model_access(1'b1, 32'h1000000C, 32'h0, 4'hF);
    @(posedge clk); #1;
    chk("hold.ack0", {31'd0, Mem_ack}, 32'd1);
    chk("hold.data0", Dato_Mem_out, 32'hCAFE0003);
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      Dir_Mem = (c % 2 == 1) ? 32'h10000014 : 32'h10000030;
      @(posedge clk); #1;
      chk("hold.ack", {31'd0, Mem_ack}, 32'd1);
      chk("hold.data", Dato_Mem_out, 32'hCAFE0003);
      chk("hold.err", {31'd0, Mem_err}, 32'd0);
    end
    @(negedge clk);
    Mem_rd = 1'b1;
    @(posedge clk); #1;
    chk("hold.release", {31'd0, Mem_ack}, 32'd0);

    // Reset while in HOLD after a write to reg 1
    @(negedge clk);
    Mem_wr = 1'b0;
    Dir_Mem = 32'h10000004;
    Dato_Mem_in = 32'h12345678;
    @(posedge clk); #1;
    chk("rsthold.ack", {31'd0, Mem_ack}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rsthold.async", {31'd0, Mem_ack}, 32'd0);
    Mem_wr = 1'b1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    access("rsthold.rd1", 1'b0, 1'b1, 32'h10000004, 32'h0, 4'hF);
    chk("rsthold.r1zero", Dato_Mem_out, 32'h0);

    // Strobe held low through reset release starts a fresh access
    access("wr_r7", 1'b1, 1'b0, 32'h1000001C, 32'h77777777, 4'hF);
    @(negedge clk);
    rst_n = 1'b0;
    Mem_rd = 1'b0;
    Dir_Mem = 32'h1000001C;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_access(1'b1, 32'h1000001C, 32'h0, 4'hF);
    @(posedge clk); #1;
    chk("rstheld.ack", {31'd0, Mem_ack}, 32'd1);
    chk("rstheld.data", Dato_Mem_out, m_out);
    @(negedge clk);
    Mem_rd = 1'b1;
    @(posedge clk); #1;
    chk("rstheld.drop", {31'd0, Mem_ack}, 32'd0);

`ifdef MEM_BANK_BYTE_EN
    access("be_init", 1'b1, 1'b0, 32'h10000008, 32'hAABBCCDD, 4'hF);
    access("be_0101", 1'b1, 1'b0, 32'h10000008, 32'h11223344, 4'b0101);
    access("be_rd", 1'b0, 1'b1, 32'h10000008, 32'h0, 4'hF);
    chk("be_val", Dato_Mem_out, 32'hAA22CC44);
    access("be_none", 1'b1, 1'b0, 32'h10000008, 32'h99999999, 4'b0000);
    access("be_rd2", 1'b0, 1'b1, 32'h10000008, 32'h0, 4'b0000);
`endif

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: a = 32'(BASE + 4 * $urandom_range(0, NREGS-1));
        1: a = 32'(BASE + $urandom_range(0, 4*NREGS + 8));
        2: a = 32'(BASE - $urandom_range(1, 16));
        default: a = 32'(BASE + 4 * $urandom_range(NREGS, NREGS + 4));
      endcase
      d = $urandom;
`ifdef MEM_BANK_BYTE_EN
      be = 4'($urandom_range(0, 15));
`else
      be = 4'hF;
`endif
      op = $urandom_range(0, 2);
      case (op)
        0: access("rnd_rd", 1'b0, 1'b1, a, d, be);
        1: access("rnd_wr", 1'b1, 1'b0, a, d, be);
        default: access("rnd_both", 1'b0, 1'b0, a, d, be);
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    read_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
